// File: rtl/hd_sync_gen.sv
// HD raster timing generator: pixel strobe, hsync/vsync, data-enable and position,
// with optional genlock of the vertical counter to a PAL frame-end pulse.
//
// state   | meaning
// IDLE    | no lock event waiting
// PENDING | frame-end seen, vertical counter is loaded at the next line wrap
module hd_sync_gen #(
    parameter int H_ACT     = 1280,
    parameter int H_FP      = 440,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACT     = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter int CLK_DIV   = 2,
    parameter int LOCK_LINE = 0,
    parameter int LOCK_TOL  = 1
) (
    input  logic        clk_out,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_lock_en,
    input  logic        i_frame_end,
    output logic        o_hd_clk,
    output logic        o_hd_hsync,
    output logic        o_hd_vsync,
    output logic        o_hd_de,
    output logic [11:0] o_hd_hpos,
    output logic [10:0] o_hd_vpos,
    output logic        o_frame_start,
    output logic        o_locked
);

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int DW    = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    localparam logic [11:0] H_LAST   = 12'(H_TOT - 1);
    localparam logic [11:0] H_ACT_W  = 12'(H_ACT);
    localparam logic [11:0] HS_FIRST = 12'(H_ACT + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_ACT + H_FP + H_SYNC - 1);

    localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACT);
    localparam logic [10:0] VS_FIRST = 11'(V_ACT + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACT + V_FP + V_SYNC - 1);
    localparam logic [10:0] LOCK_V   = 11'(LOCK_LINE);

    localparam logic signed [11:0] V_TOT_S     = 12'(V_TOT);
    localparam logic signed [11:0] V_HALF_S    = 12'(V_TOT / 2);
    localparam logic signed [11:0] LOCK_LINE_S = 12'(LOCK_LINE);
    localparam logic signed [11:0] LOCK_TOL_S  = 12'(LOCK_TOL);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } lock_state_t;

    lock_state_t state_q, state_d;

    logic [DW-1:0] div_cnt;
    logic [11:0]   h_cnt;
    logic [10:0]   v_cnt;

    logic        pix_en;
    logic        h_wrap;
    logic        lock_apply;
    logic        locked_d;
    logic        in_tol;
    logic [10:0] v_inc;
    logic [10:0] v_next;
    logic signed [11:0] v_err;
    logic signed [11:0] v_abs;
    logic signed [11:0] v_dist;

    assign pix_en     = i_enable && (div_cnt == DIV_LAST);
    assign h_wrap     = pix_en && (h_cnt == H_LAST);
    assign v_inc      = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    assign lock_apply = i_lock_en && h_wrap && ((state_q == PENDING) || i_frame_end);
    assign v_next     = lock_apply ? LOCK_V : v_inc;

    // Line error is taken around the frame circle: shortest distance modulo V_TOT.
    assign v_err  = $signed({1'b0, v_inc}) - LOCK_LINE_S;
    assign v_abs  = v_err[11] ? -v_err : v_err;
    assign v_dist = (v_abs > V_HALF_S) ? (V_TOT_S - v_abs) : v_abs;
    assign in_tol = (v_dist <= LOCK_TOL_S);

    always_comb begin
        state_d  = state_q;
        locked_d = o_locked;
        if (!i_lock_en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else if (lock_apply) begin
            state_d  = IDLE;
            locked_d = in_tol;
        end else if ((state_q == IDLE) && i_frame_end) begin
            state_d = PENDING;
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            o_locked <= 1'b0;
        end else if (!i_enable) begin
            state_q  <= IDLE;
            o_locked <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_locked <= locked_d;
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else if (!i_enable) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= pix_en ? '0 : div_cnt + DW'(1);
            if (pix_en) begin
                h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
                if (h_wrap) begin
                    v_cnt <= v_next;
                end
            end
        end
    end

    // Decoded outputs trail the counters by one clk_out.
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            o_hd_clk      <= 1'b0;
            o_hd_hsync    <= 1'b0;
            o_hd_vsync    <= 1'b0;
            o_hd_de       <= 1'b0;
            o_hd_hpos     <= '0;
            o_hd_vpos     <= '0;
            o_frame_start <= 1'b0;
        end else if (!i_enable) begin
            o_hd_clk      <= 1'b0;
            o_hd_hsync    <= 1'b0;
            o_hd_vsync    <= 1'b0;
            o_hd_de       <= 1'b0;
            o_hd_hpos     <= '0;
            o_hd_vpos     <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_hd_clk      <= (div_cnt < DIV_HALF);
            o_hd_hsync    <= (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
            o_hd_vsync    <= (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
            o_hd_de       <= (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
            o_hd_hpos     <= h_cnt;
            o_hd_vpos     <= v_cnt;
            o_frame_start <= h_wrap && (v_next == 11'd0);
        end
    end

endmodule

// File: doc/hd_sync_gen.md
Name: hd_sync_gen

Overview:
- Generates the HD raster timing consumed by the PAL-to-HD line-buffer reader:
  - a pixel strobe (o_hd_clk square wave; the consumer advances on its falling edge)
  - active-high hsync and vsync
  - data-enable and raster position
- Optional genlock: each PAL frame-end pulse pulls the vertical counter to a fixed line, so the HD frame stays phase-locked to the incoming PAL frame and the line buffer never over- or under-runs.

Parameters:
- H_ACT, 1280, active pixels per line
- H_FP, 440, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACT, 720, active lines
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- CLK_DIV, 2, clk_out cycles per pixel (>=2)
- LOCK_LINE, 0, vertical count loaded on a lock event
- LOCK_TOL, 1, max |line error| still reported as locked

Ports:
- clk_out  in  1  system clock; all logic is in this domain
- reset  in  1  asynchronous, active-high reset
- i_enable  in  1  run timing; low = hold idle
- i_lock_en  in  1  apply frame-end lock events
- i_frame_end  in  1  one-cycle PAL frame-end pulse, already in clk_out domain
- o_hd_clk  out  1  pixel strobe square wave
- o_hd_hsync  out  1  horizontal sync, active high
- o_hd_vsync  out  1  vertical sync, active high
- o_hd_de  out  1  active video
- o_hd_hpos  out  12  horizontal counter
- o_hd_vpos  out  11  vertical counter
- o_frame_start  out  1  one-cycle pulse at raster origin
- o_locked  out  1  last lock event was within tolerance

Behaviour:
- Totals: H_TOT = H_ACT+H_FP+H_SYNC+H_BP; V_TOT likewise.
- Reset (async): all counters and lock state cleared; every output is 0.
- i_enable=0:
  - div/h/v counters and the pending flag are cleared synchronously.
  - All outputs are 0 on the next clk_out edge.
- div_cnt: 0..CLK_DIV-1, wraps; pix_en = (div_cnt == CLK_DIV-1).
- o_hd_clk is registered: 1 while div_cnt < CLK_DIV/2 (integer division), else 0. CLK_DIV=2 gives a 1,0 sequence.
- h_cnt advances on pix_en and wraps H_TOT-1 -> 0.
- At the h wrap, v_cnt advances and wraps V_TOT-1 -> 0, unless a lock is applied.
- Decode (registered, 1 clk_out latency from counters; hpos/vpos are the same registered copies):
  - hsync = h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1]
  - vsync = v_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC-1], whole lines (changes only at the h wrap)
  - de = h_cnt < H_ACT and v_cnt < V_ACT
- o_frame_start: 1 for one cycle when pix_en and the counters move to h=0, v=0 (including a lock to LOCK_LINE=0).
- Lock state machine:
  - States: IDLE -> PENDING on i_frame_end (i_lock_en=1).
  - PENDING -> IDLE at the next h wrap (pix_en and h_cnt==H_TOT-1):
    - v_cnt is loaded with LOCK_LINE, not incremented.
    - o_locked <= (|v_next - LOCK_LINE| <= LOCK_TOL), where v_next is the unlocked next value; the difference is modulo V_TOT, shortest distance.
  - i_frame_end in the same cycle as the h wrap: applied at that wrap.
  - Further pulses while PENDING are ignored; one jump only.
  - i_lock_en=0: pulses are ignored, PENDING is cleared, o_locked=0.
  - o_locked holds its value between lock events.
- Arithmetic: counters are unsigned. The lock-error compare uses signed width(v)+1 bits.
- Reset mid-line or mid-frame returns to h=0, v=0, div=0, IDLE.

Test Plan:
Small parameters for all scenarios: H 8/2/2/2 (H_TOT=14), V 4/1/1/1 (V_TOT=7), CLK_DIV=2, LOCK_LINE=0, LOCK_TOL=1.
- Free run, i_lock_en=0 -> o_hd_clk toggles every cycle; hsync high for h=10..11; de high for h 0..7 on v 0..3; vsync high for all of v=5; o_frame_start every 196 clk_out cycles.
- i_frame_end with v_cnt=6 at h=3 -> at the h wrap, v loads 0 (v_next=0, error 0); o_frame_start pulses; o_locked=1.
- i_frame_end with v_cnt=2 -> v loads 0 instead of 3; o_locked=0; the next frame then reaches v=6 normally.
- Two i_frame_end pulses within one line -> exactly one jump; the following line increments normally.
- i_frame_end coincident with the h-wrap cycle -> the jump is applied at that same wrap.
- Async reset asserted mid-line, e.g. h=5, v=3 -> all outputs 0 immediately. After release: o_hd_clk=1 on the first cycle, and the counters restart from 0.
